// File: rtl/checker_memory_pkg.sv
// Shared parameter defaults and helpers for the banked checker memory.
// Covers the address-width derivation and the Wishbone byte-order swaps.
package checker_memory_pkg;

    localparam int unsigned LANES_DEF         = 8;
    localparam int unsigned ROW_BITS_DEF      = 12;
    localparam int unsigned MPU_BYTES_DEF     = 6;
    localparam int unsigned WB_BIG_ENDIAN_DEF = 1;

    function automatic int unsigned abits(input int unsigned lanes, input int unsigned row_bits);
        return $clog2(lanes) + row_bits;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [3:0] selrev4(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

endpackage

// File: rtl/checker_memory_banked_if.sv
// Classic Wishbone slave bus used by checker_memory_banked.
interface checker_memory_banked_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/checker_memory_lane.sv
// One byte-wide lane: write/read port A, read-only port B, both write-first.
module checker_memory_lane #(
    parameter int unsigned ROW_BITS = 12
) (
    input  logic                sys_clk,
    input  logic                we_a,
    input  logic [ROW_BITS-1:0] addr_a,
    input  logic [7:0]          din_a,
    output logic [7:0]          dout_a,
    input  logic [ROW_BITS-1:0] addr_b,
    output logic [7:0]          dout_b
);

    logic [7:0] mem [2**ROW_BITS];

    always_ff @(posedge sys_clk) begin
        if (we_a) mem[addr_a] <= din_a;
        dout_a <= we_a ? din_a : mem[addr_a];
        dout_b <= (we_a && (addr_b == addr_a)) ? din_a : mem[addr_b];
    end

endmodule

// File: rtl/checker_memory_banked.sv
// Byte-banked memory: Wishbone word port plus an unaligned multi-byte MPU fetch port.
// Byte address b lives in lane b mod LANES, row b / LANES.
module checker_memory_banked
    import checker_memory_pkg::*;
#(
    parameter int unsigned LANES         = LANES_DEF,
    parameter int unsigned ROW_BITS      = ROW_BITS_DEF,
    parameter int unsigned MPU_BYTES     = MPU_BYTES_DEF,
    parameter int unsigned WB_BIG_ENDIAN = WB_BIG_ENDIAN_DEF,
    localparam int unsigned ABITS        = abits(LANES, ROW_BITS)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    checker_memory_banked_if.slave wb,
    input  logic                   mpu_en,
    input  logic [ABITS-1:0]       mpu_addr,
    output logic [8*MPU_BYTES-1:0] mpu_do,
    output logic                   mpu_valid
);

    localparam int unsigned LB = $clog2(LANES);
    localparam int unsigned MW = 8 * MPU_BYTES;

    logic [LB-1:0]       mpu_lane, rot_sel, wb_lo, rd_lo;
    logic [ROW_BITS-1:0] mpu_row, wb_row;
    logic                take, in_range, wr_go;
    logic                ack, err, rd_ack;
    logic [31:0]         wdat_ord, rd_ord, rd_word, wb_dat_q;
    logic [3:0]          wsel_ord;
    logic [MW-1:0]       mpu_rot, mpu_do_q;
    logic [7:0]          dout_a [LANES];
    logic [7:0]          dout_b [LANES];
    logic                unused_adr;

    assign unused_adr = ^wb.wb_adr_i[1:0];

    assign mpu_lane = mpu_addr[LB-1:0];
    assign mpu_row  = mpu_addr[ABITS-1:LB];

    assign take     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~wb.wb_err_o & ~sys_rst;
    assign in_range = (wb.wb_adr_i[31:ABITS] == '0);
    assign wr_go    = take & in_range & wb.wb_we_i;
    assign wb_lo    = wb.wb_adr_i[LB-1:0] & ~LB'(3);
    assign wb_row   = wb.wb_adr_i[ABITS-1:LB];
    assign wdat_ord = (WB_BIG_ENDIAN != 0) ? bswap32(wb.wb_dat_i) : wb.wb_dat_i;
    assign wsel_ord = (WB_BIG_ENDIAN != 0) ? selrev4(wb.wb_sel_i) : wb.wb_sel_i;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [LB-1:0] LID = LB'(l);
        logic                hit;
        logic [ROW_BITS-1:0] row_b;

        assign hit   = ((LID & ~LB'(3)) == wb_lo);
        // Lanes below the start lane belong to the next row of a straddling fetch.
        assign row_b = (LID < mpu_lane) ? mpu_row + ROW_BITS'(1) : mpu_row;

        checker_memory_lane #(.ROW_BITS(ROW_BITS)) u_lane (
            .sys_clk (sys_clk),
            .we_a    (wr_go & hit & wsel_ord[l % 4]),
            .addr_a  (wb_row),
            .din_a   (wdat_ord[8*(l % 4) +: 8]),
            .dout_a  (dout_a[l]),
            .addr_b  (row_b),
            .dout_b  (dout_b[l])
        );
    end

    always_comb begin
        rd_ord = '0;
        for (int unsigned k = 0; k < 4; k++) rd_ord[8*k +: 8] = dout_a[rd_lo + LB'(k)];
    end

    assign rd_word = (WB_BIG_ENDIAN != 0) ? bswap32(rd_ord) : rd_ord;

    always_comb begin
        mpu_rot = '0;
        for (int unsigned j = 0; j < MPU_BYTES; j++) mpu_rot[MW-1-8*j -: 8] = dout_b[rot_sel + LB'(j)];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ack       <= 1'b0;
            err       <= 1'b0;
            rd_ack    <= 1'b0;
            wb_dat_q  <= '0;
            mpu_valid <= 1'b0;
            mpu_do_q  <= '0;
        end else begin
            ack       <= take & in_range;
            err       <= take & ~in_range;
            rd_ack    <= take & in_range & ~wb.wb_we_i;
            mpu_valid <= mpu_en;
            if (rd_ack) wb_dat_q <= rd_word;
            if (mpu_valid) mpu_do_q <= mpu_rot;
        end
        if (take) rd_lo <= wb_lo;
        if (mpu_en) rot_sel <= mpu_lane;
    end

    // RAM outputs move on every access; the _q copies hold them outside valid cycles.
    assign wb.wb_ack_o = ack;
    assign wb.wb_err_o = err;
    assign wb.wb_dat_o = rd_ack ? rd_word : wb_dat_q;
    assign mpu_do      = mpu_valid ? mpu_rot : mpu_do_q;

endmodule
